// File: rtl/qif_neuron_array.sv
// rtl/qif_neuron_array.sv - multi-channel quadratic integrate-and-fire neuron array with refractory hold
module qif_neuron_array #(
    parameter int WIDTH   = 8,
    parameter int N_CH    = 4,
    parameter int V_TH    = 50,
    parameter int V_RESET = -20,
    parameter int I_SHIFT = 2,
    parameter int V_SHIFT = 3,
    parameter int REFRAC  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N_CH*WIDTH-1:0]   I_syn,
    output logic [N_CH*WIDTH-1:0]   V_mem,
    output logic [N_CH-1:0]         spike,
    output logic [N_CH-1:0]         refrac
);

    localparam int CW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int SW = 2 * WIDTH + 2;

    localparam logic signed [WIDTH-1:0] TH_V    = WIDTH'(V_TH);
    localparam logic signed [WIDTH-1:0] RESET_V = WIDTH'(V_RESET);
    localparam logic signed [SW-1:0]    V_MAX   = SW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0]    V_MIN   = SW'(-(1 << (WIDTH - 1)));
    localparam logic [CW-1:0]           REFRAC_LOAD = CW'(REFRAC);

    function automatic logic signed [SW-1:0] sx(input logic signed [WIDTH-1:0] x);
        return {{(SW - WIDTH){x[WIDTH-1]}}, x};
    endfunction

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic signed [WIDTH-1:0] v_q, v_d;
        logic [CW-1:0]           cnt_q, cnt_d;
        logic                    spk_q, spk_d;
        logic signed [WIDTH-1:0] i_ch, i_sh, v_sh;
        logic signed [SW-1:0]    sum;
        logic signed [WIDTH-1:0] v_sat;

        // Wide sum: the square of a WIDTH-bit value plus two WIDTH-bit terms cannot overflow SW bits.
        always_comb begin
            i_ch  = I_syn[k*WIDTH +: WIDTH];
            i_sh  = i_ch >>> I_SHIFT;
            v_sh  = v_q >>> V_SHIFT;
            sum   = sx(v_q) + sx(i_sh) + sx(v_sh) * sx(v_sh);
            v_sat = sum[WIDTH-1:0];
            if (sum > V_MAX) begin
                v_sat = V_MAX[WIDTH-1:0];
            end else if (sum < V_MIN) begin
                v_sat = V_MIN[WIDTH-1:0];
            end
        end

        always_comb begin
            v_d   = v_q;
            cnt_d = cnt_q;
            spk_d = 1'b0;
            if (en) begin
                if (v_q >= TH_V) begin
                    v_d   = RESET_V;
                    spk_d = 1'b1;
                    cnt_d = REFRAC_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    v_d = v_sat;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n) begin
                v_q   <= '0;
                cnt_q <= '0;
                spk_q <= 1'b0;
            end else begin
                v_q   <= v_d;
                cnt_q <= cnt_d;
                spk_q <= spk_d;
            end
        end

        assign V_mem[k*WIDTH +: WIDTH] = v_q;
        assign spike[k]                = spk_q;
        assign refrac[k]               = (cnt_q != '0);
    end

endmodule

// File: tb/tb_qif_neuron_array.sv
// tb/tb_qif_neuron_array.sv - scoreboard bench for qif_neuron_array against an integer reference model
module tb_qif_neuron_array;

    localparam int W = 8;
    localparam int N = 4;
    localparam int NOGOLD = 9999;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic [31:0]  isyn0 = '0, isyn1 = '0;
    logic [31:0]  vmem0, vmem1;
    logic [3:0]   spk0, spk1, ref0, ref1;

    always #5 clk = ~clk;

    qif_neuron_array dut (
        .clk(clk), .rst_n(rst_n), .en(en), .I_syn(isyn0),
        .V_mem(vmem0), .spike(spk0), .refrac(ref0)
    );

    qif_neuron_array #(.V_TH(127)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .I_syn(isyn1),
        .V_mem(vmem1), .spike(spk1), .refrac(ref1)
    );

    typedef struct {
        logic [31:0] v0, v1;
        logic [3:0]  s0, s1, r0, r1;
        int          g0, g1;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    int mv[2][N];
    int mc[2][N];
    int ms[2][N];
    int th[2] = '{50, 127};

    function automatic int fdiv(int x, int s);
        return (x >= 0) ? (x >>> s) : -(((-x) + (1 << s) - 1) >>> s);
    endfunction

    function automatic int clamp(int x);
        return (x > 127) ? 127 : ((x < -128) ? -128 : x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [31:0] a, input logic [31:0] b,
                        input int g0, input int g1);
        exp_t it;
        int   cur;
        @(negedge clk);
        rst_n = r;
        en    = e;
        isyn0 = a;
        isyn1 = b;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                cur = (d == 0) ? int'($signed(a[k*W +: W])) : int'($signed(b[k*W +: W]));
                if (r) begin
                    mv[d][k] = 0; mc[d][k] = 0; ms[d][k] = 0;
                end else if (!e) begin
                    ms[d][k] = 0;
                end else if (mv[d][k] >= th[d]) begin
                    mv[d][k] = -20; mc[d][k] = 3; ms[d][k] = 1;
                end else if (mc[d][k] > 0) begin
                    mc[d][k] = mc[d][k] - 1; ms[d][k] = 0;
                end else begin
                    mv[d][k] = clamp(mv[d][k] + fdiv(cur, 2) + fdiv(mv[d][k], 3) * fdiv(mv[d][k], 3));
                    ms[d][k] = 0;
                end
            end
        end
        it.v0 = '0; it.v1 = '0; it.s0 = '0; it.s1 = '0; it.r0 = '0; it.r1 = '0;
        for (int k = 0; k < N; k++) begin
            it.v0[k*W +: W] = W'(mv[0][k]);
            it.v1[k*W +: W] = W'(mv[1][k]);
            it.s0[k] = (ms[0][k] != 0);
            it.s1[k] = (ms[1][k] != 0);
            it.r0[k] = (mc[0][k] != 0);
            it.r1[k] = (mc[1][k] != 0);
        end
        it.g0 = g0;
        it.g1 = g1;
        q.push_back(it);
    endtask

    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("v_mem", vmem0, mon_e.v0);
            chk("spike", {28'b0, spk0}, {28'b0, mon_e.s0});
            chk("refrac", {28'b0, ref0}, {28'b0, mon_e.r0});
            chk("v_mem_sat", vmem1, mon_e.v1);
            chk("spike_sat", {28'b0, spk1}, {28'b0, mon_e.s1});
            chk("refrac_sat", {28'b0, ref1}, {28'b0, mon_e.r1});
            if (mon_e.g0 != NOGOLD) chk("gold_ch0", {24'b0, vmem0[7:0]}, {24'b0, 8'(mon_e.g0)});
            if (mon_e.g1 != NOGOLD) chk("gold_sat_ch0", {24'b0, vmem1[7:0]}, {24'b0, 8'(mon_e.g1)});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int fire_seq[9] = '{10, 21, 35, 61, -20, -20, -20, -20, -1};
    int sat_seq[4]  = '{31, 71, 127, -20};
    int gate_seq[8] = '{10, 21, 21, 21, 21, 21, 21, 35};
    logic [31:0] main_i;

    initial begin
        main_i = {8'd0, 8'hF8, 8'd0, 8'd40};

        step(1'b1, 1'b1, $urandom, $urandom, 0, 0);
        step(1'b1, 1'b0, $urandom, $urandom, 0, 0);

        for (int i = 0; i < 9; i++)
            step(1'b0, 1'b1, {8'($urandom), main_i[23:0]}, {$urandom_range(255) , 24'h00007F} & 32'hFF_FFFF_FF | 32'h0000_007F & 32'h0000_00FF,
                 fire_seq[i], (i < 4) ? sat_seq[i] : NOGOLD);

        step(1'b1, 1'b0, $urandom, $urandom, 0, 0);
        for (int i = 0; i < 8; i++)
            step(1'b0, (i < 2 || i == 7), (i < 2 || i == 7) ? main_i : $urandom, $urandom,
                 gate_seq[i], NOGOLD);

        step(1'b1, 1'b0, $urandom, $urandom, 0, 0);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, main_i, $urandom, fire_seq[i], NOGOLD);
        step(1'b1, 1'b1, main_i, $urandom, 0, 0);
        step(1'b0, 1'b1, main_i, $urandom, 10, NOGOLD);
        step(1'b0, 1'b1, main_i, $urandom, 21, NOGOLD);

        for (int i = 0; i < 300; i++)
            step(($urandom_range(99) < 3), ($urandom_range(3) != 0), $urandom, $urandom,
                 NOGOLD, NOGOLD);

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
